memory_access_stage: RTL and testbench

//  Pipeline MEM stage, directly upstream of writeback; drives the MEM_WB_* register set.

---
 rtl/memory_access_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_memory_access_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues req/gnt + rvalid data-memory transactions for
// loads/stores, aligns store bytes, extracts/extends load data, and drives
// the MEM_WB register set. mem_hold freezes upstream while an access is open.

// One byte lane of the store path: picks the byte this lane drives and
// whether the lane is enabled for the current access size/offset.
module mem_access_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] i_size,  // 00 B, 01 H, 1x W
  input  logic [1:0] i_a,     // byte offset within the word
  input  logic [7:0] i_b,     // store byte 0 (byte replication source)
  input  logic [7:0] i_h,     // byte of the low half that maps to this lane
  input  logic [7:0] i_w,     // byte of the full word that maps to this lane
  output logic [7:0] o_byte,
  output logic       o_be
);
  localparam logic [1:0] L = 2'(LANE);

  // Size decides both data source and enable for this lane
  always_comb begin
    o_byte = i_w;
    o_be   = 1'b1;
    case (i_size)
      2'b00: begin
        o_byte = i_b;
        o_be   = (i_a == L);
      end
      2'b01: begin
        o_byte = i_h;
        o_be   = (i_a[1] == L[1]);
      end
      default: ;
    endcase
  end
endmodule

module memory_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic        dbg,
  input  logic        f_stall,
  input  logic [31:0] EX_MEM_alures,
  input  logic [31:0] EX_MEM_storedata,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic [2:0]  EX_MEM_funct3,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_regwrite,
  input  logic        EX_MEM_CSR_read,
  input  logic [31:0] EX_MEM_CSR,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_hold,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic [31:0] MEM_WB_alures,
  output logic [31:0] MEM_WB_memres,
  output logic [31:0] MEM_WB_CSR,
  output logic [4:0]  MEM_WB_rd,
  output logic        MEM_WB_memread,
  output logic        MEM_WB_regwrite,
  output logic        MEM_WB_CSR_read
);
  localparam int         NUM_LANES = 4;
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_timer;
  logic [31:0] r_memres;   // completion data held while the pipe is frozen
  logic        r_kill;     // completion suppressed regwrite (bus error)

  logic        w_adv, w_is_mem, w_mis, w_go, w_signed;
  logic [1:0]  w_size, w_a;
  logic [31:0] w_shift, w_ext;
  logic        w_cmpl, w_hold, w_req, w_tout, w_mexc;
  logic [31:0] w_cap_res;
  logic        w_cap_kill;

  assign w_adv    = !dbg && !f_stall;
  assign w_a      = EX_MEM_alures[1:0];
  assign w_size   = EX_MEM_funct3[1:0];
  assign w_signed = !EX_MEM_funct3[2];
  assign w_is_mem = EX_MEM_memread || EX_MEM_memwrite;
  assign w_mis    = w_is_mem && (w_size[1] ? (w_a != 2'b00) : (w_size[0] && w_a[0]));
  assign w_go     = w_is_mem && !w_mis;

  // Store path: word-aligned address, per-lane data and enables
  assign dmem_addr = {EX_MEM_alures[31:2], 2'b00};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_access_lane #(.LANE(g)) u_lane (
      .i_size (w_size),
      .i_a    (w_a),
      .i_b    (EX_MEM_storedata[7:0]),
      .i_h    (EX_MEM_storedata[8*(g%2) +: 8]),
      .i_w    (EX_MEM_storedata[8*g +: 8]),
      .o_byte (dmem_wdata[8*g +: 8]),
      .o_be   (dmem_be[g])
    );
  end

  // Load path: shift the addressed byte/half down, then extend. Word loads
  // are aligned so the shift is zero and the full word passes through.
  assign w_shift = dmem_rdata >> {w_a, 3'b000};

  // Sign/zero extension by access size
  always_comb begin
    w_ext = w_shift;
    case (w_size)
      2'b00:   w_ext = {{24{w_signed & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_ext = {{16{w_signed & w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end

  // Next state, hold and completion decode
  always_comb begin
    w_next     = r_state;
    w_hold     = 1'b0;
    w_req      = 1'b0;
    w_cmpl     = 1'b0;
    w_tout     = 1'b0;
    w_mexc     = 1'b0;
    w_cap_res  = 32'b0;
    w_cap_kill = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_next = REQ;
          w_hold = 1'b1;
        end else begin
          // non-memory or misaligned op retires here without a bus access
          w_cmpl     = 1'b1;
          w_cap_kill = w_mis;
          w_mexc     = w_mis && w_adv;
        end
      end
      REQ: begin
        w_req  = 1'b1;
        w_hold = 1'b1;
        // rvalid in the grant cycle belongs to nobody and is dropped
        if (dmem_gnt) begin
          if (EX_MEM_memwrite) w_cmpl = 1'b1;
          else                 w_next = RESP;
        end
      end
      RESP: begin
        w_hold = 1'b1;
        if (dmem_rvalid) begin
          w_cmpl    = 1'b1;
          w_cap_res = w_ext;
        end else if (r_timer == TO_LAST) begin
          w_cmpl     = 1'b1;
          w_tout     = 1'b1;
          w_cap_kill = 1'b1;
        end
      end
      DONE: begin
        w_hold     = 1'b1;
        w_cmpl     = 1'b1;
        w_cap_res  = r_memres;
        w_cap_kill = r_kill;
      end
      default: w_next = IDLE;
    endcase
    // a bus completion either retires now or parks in DONE until the pipe moves
    if (r_state != IDLE && w_cmpl) begin
      if (w_adv) begin
        w_hold = 1'b0;
        w_next = IDLE;
      end else begin
        w_next = DONE;
      end
    end
  end

  // Reset gates the combinational controls so they drop immediately
  assign dmem_req     = w_req && Rst_n;
  assign dmem_we      = w_req && EX_MEM_memwrite;
  assign mem_hold     = w_hold && Rst_n;
  assign misalign_exc = w_mexc && Rst_n;
  assign bus_err      = w_tout && Rst_n;

  // State register, response timer and parked completion data
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= IDLE;
      r_timer  <= 8'd0;
      r_memres <= 32'b0;
      r_kill   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == REQ)       r_timer <= 8'd0;
      else if (r_state == RESP) r_timer <= r_timer + 8'd1;
      if (w_cmpl && !w_adv && r_state != IDLE) begin
        r_memres <= w_cap_res;
        r_kill   <= w_cap_kill;
      end
    end
  end

  // MEM_WB capture on a completing, non-stalled cycle
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      MEM_WB_alures   <= 32'b0;
      MEM_WB_memres   <= 32'b0;
      MEM_WB_CSR      <= 32'b0;
      MEM_WB_rd       <= 5'b0;
      MEM_WB_memread  <= 1'b0;
      MEM_WB_regwrite <= 1'b0;
      MEM_WB_CSR_read <= 1'b0;
    end else if (w_cmpl && w_adv) begin
      MEM_WB_alures   <= EX_MEM_alures;
      MEM_WB_memres   <= w_cap_res;
      MEM_WB_CSR      <= EX_MEM_CSR;
      MEM_WB_rd       <= EX_MEM_rd;
      MEM_WB_memread  <= EX_MEM_memread && !w_mis;
      MEM_WB_regwrite <= EX_MEM_regwrite && !w_mis && !w_cap_kill;
      MEM_WB_CSR_read <= EX_MEM_CSR_read;
    end
  end
endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage with a transaction-level model:
// each op is driven with a planned grant delay, response delay and stall
// pattern; expected bus signals, hold, pulses and MEM_WB are derived from
// the access rules directly.
module tb_memory_access_stage;
  localparam int TO = 4;

  logic        clk = 1'b0, Rst_n = 1'b0, dbg = 1'b0, f_stall = 1'b0;
  logic [31:0] alures = '0, sdata = '0, csr = '0;
  logic        memread = 1'b0, memwrite = 1'b0, regwrite = 1'b0, csr_read = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic        gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;

  logic        dmem_req, dmem_we, mem_hold, misalign_exc, bus_err;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] wb_alures, wb_memres, wb_csr;
  logic [4:0]  wb_rd;
  logic        wb_memread, wb_regwrite, wb_csr_read;

  int n_cmp = 0, n_err = 0;

  memory_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .Rst_n(Rst_n), .dbg(dbg), .f_stall(f_stall),
    .EX_MEM_alures(alures), .EX_MEM_storedata(sdata),
    .EX_MEM_memread(memread), .EX_MEM_memwrite(memwrite),
    .EX_MEM_funct3(funct3), .EX_MEM_rd(rd), .EX_MEM_regwrite(regwrite),
    .EX_MEM_CSR_read(csr_read), .EX_MEM_CSR(csr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(gnt),
    .dmem_rvalid(rvalid), .dmem_rdata(rdata),
    .mem_hold(mem_hold), .misalign_exc(misalign_exc), .bus_err(bus_err),
    .MEM_WB_alures(wb_alures), .MEM_WB_memres(wb_memres), .MEM_WB_CSR(wb_csr),
    .MEM_WB_rd(wb_rd), .MEM_WB_memread(wb_memread),
    .MEM_WB_regwrite(wb_regwrite), .MEM_WB_CSR_read(wb_csr_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // expected load result from the word, offset and size/sign code
  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    v = w;
    case (f3)
      3'b000: begin v = (w >> (8 * a)) & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
      3'b100:       v = (w >> (8 * a)) & 32'hFF;
      3'b001: begin v = (w >> (8 * a)) & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
      3'b101:       v = (w >> (8 * a)) & 32'hFFFF;
      default:      v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] f_be(input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] one, three;
    one = 1; three = 3;
    case (f3[1:0])
      2'b00:   return one << a;
      2'b01:   return three << a;
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return (d & 32'hFF) * 32'h0101_0101;
      2'b01:   return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Drive one op from an IDLE start until its MEM_WB capture; called at negedge.
  task automatic run_op(input logic t_rd, input logic t_wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] d,
                        input int gdly, input int rdly, input logic [31:0] rword,
                        input bit rnd_stall, input logic [7:0] fmask,
                        input string nm, output int ncyc);
    logic mis, amem, granted, done, tout, got_data, comp, adv_now;
    logic exp_req, exp_hold, exp_berr, exp_mexc;
    logic [31:0] exp_res;
    int reqn, k, c;
    alures = addr; sdata = d; memread = t_rd; memwrite = t_wr; funct3 = f3;
    rd = 5'($urandom); regwrite = 1'($urandom); csr = $urandom; csr_read = 1'($urandom);
    mis  = (t_rd || t_wr) && ((f3[1:0] == 2'b10 && addr[1:0] != 2'b00) ||
                              (f3[1:0] == 2'b01 && addr[0]));
    amem = (t_rd || t_wr) && !mis;
    granted = 0; done = !amem; tout = 0; got_data = 0; comp = 0; reqn = 0; k = 0;
    for (c = 0; c < 200 && !comp; c++) begin
      if (rnd_stall) begin
        dbg = ($urandom % 8) == 0;
        f_stall = ($urandom % 6) == 0;
      end else begin
        dbg = 0;
        f_stall = (c < 8) ? fmask[c] : 1'b0;
      end
      adv_now = !dbg && !f_stall;
      gnt = 0; rvalid = 0; rdata = $urandom;
      exp_req = amem && c >= 1 && !granted;
      exp_berr = 0;
      if (exp_req) begin
        if (reqn == gdly) begin
          gnt = 1; granted = 1;
          if (t_wr) done = 1;
          else if ($urandom % 4 == 0) rvalid = 1;  // must be ignored
        end
        reqn++;
      end else if (granted && t_rd && !done) begin
        k++;
        if (k == rdly) begin
          rvalid = 1; rdata = rword; done = 1; got_data = 1;
        end else if (k == TO) begin
          done = 1; tout = 1; exp_berr = 1;
        end
      end
      exp_hold = amem && !(done && adv_now);
      exp_mexc = mis && adv_now;
      comp = adv_now && (!amem || done);
      #1;
      chk({nm, ".req"},  dmem_req, exp_req);
      chk({nm, ".hold"}, mem_hold, exp_hold);
      chk({nm, ".mexc"}, misalign_exc, exp_mexc);
      chk({nm, ".berr"}, bus_err, exp_berr);
      if (exp_req) begin
        chk({nm, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({nm, ".we"}, dmem_we, t_wr);
        if (t_wr) begin
          chk({nm, ".be"}, dmem_be, f_be(f3, addr[1:0]));
          chk({nm, ".wdata"}, dmem_wdata, f_wdata(f3, d));
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    gnt = 0; rvalid = 0; dbg = 0; f_stall = 0;
    ncyc = c;
    if (!comp) begin
      chk({nm, ".timeout"}, 0, 1);
    end else begin
      exp_res = got_data ? f_load(f3, addr[1:0], rword) : 32'b0;
      chk({nm, ".memres"},  wb_memres, exp_res);
      chk({nm, ".alures"},  wb_alures, addr);
      chk({nm, ".csr"},     wb_csr, csr);
      chk({nm, ".rd"},      wb_rd, rd);
      chk({nm, ".memread"}, wb_memread, t_rd && !mis);
      chk({nm, ".regwr"},   wb_regwrite, regwrite && !mis && !tout);
      chk({nm, ".csrrd"},   wb_csr_read, csr_read);
    end
  endtask

  initial begin
    int n, kind;
    logic [2:0] f3;
    logic [31:0] a;
    logic [2:0] ldf [5];
    ldf[0] = 3'b000; ldf[1] = 3'b001; ldf[2] = 3'b010; ldf[3] = 3'b100; ldf[4] = 3'b101;

    // reset with an aligned load already presented
    memread = 1; funct3 = 3'b010; alures = 32'h100;
    #1;
    chk("rst.req",  dmem_req, 0);
    chk("rst.hold", mem_hold, 0);
    chk("rst.wb_memres", wb_memres, 0);
    chk("rst.wb_regwr",  wb_regwrite, 0);
    repeat (2) @(negedge clk);
    Rst_n = 1; memread = 0;

    run_op(1, 0, 3'b000, 32'h1003, 0, 0, 1, 32'h80FF_0011, 0, 8'h00, "lb", n);
    chk("lb.lat", n, 3);
    run_op(1, 0, 3'b100, 32'h1003, 0, 0, 1, 32'h80FF_0011, 0, 8'h00, "lbu", n);
    chk("lbu.lat", n, 3);
    run_op(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 3, 1, 0, 0, 8'h00, "sh", n);
    chk("sh.lat", n, 5);
    run_op(0, 1, 3'b010, 32'h2000, 32'hDEAD_BEEF, 0, 1, 0, 0, 8'h00, "sw", n);
    chk("sw.lat", n, 2);
    run_op(1, 0, 3'b010, 32'h0001, 0, 0, 1, 0, 0, 8'h00, "lw_mis", n);
    chk("lw_mis.lat", n, 1);
    run_op(1, 0, 3'b010, 32'h0040, 0, 0, 99, 0, 0, 8'h00, "lw_to", n);
    chk("lw_to.lat", n, 6);
    run_op(1, 0, 3'b001, 32'h0106, 0, 0, 1, 32'h9ABC_1234, 0, 8'b0000_1100, "lh_stall", n);
    chk("lh_stall.lat", n, 5);
    run_op(0, 0, 3'b000, 32'h5555_0003, 0, 0, 1, 0, 0, 8'h00, "alu", n);
    chk("alu.lat", n, 1);

    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom % 3);
      a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      f3 = (kind == 1) ? ldf[$urandom % 5] : 3'($urandom % 3);
      run_op(kind == 1, kind == 2, f3, a, $urandom, int'($urandom % 4),
             1 + int'($urandom % 6), $urandom, 1, 8'h00, "rnd", n);
    end

    // reset while a load waits in RESP
    alures = 32'h80; memread = 1; memwrite = 0; funct3 = 3'b010; regwrite = 1;
    @(negedge clk);
    gnt = 1;
    #1 chk("rsp.req", dmem_req, 1);
    @(negedge clk);
    gnt = 0;
    #1 chk("rsp.hold", mem_hold, 1);
    Rst_n = 0;
    #1;
    chk("rsp.rst_req",  dmem_req, 0);
    chk("rsp.rst_hold", mem_hold, 0);
    chk("rsp.rst_alures", wb_alures, 0);
    chk("rsp.rst_rd",   wb_rd, 0);
    chk("rsp.rst_csrrd", wb_csr_read, 0);
    @(negedge clk);
    Rst_n = 1; memread = 0; dbg = 1; rvalid = 1; rdata = 32'hFFFF_FFFF;
    #1;
    chk("rsp.late_req",  dmem_req, 0);
    chk("rsp.late_hold", mem_hold, 0);
    @(negedge clk);
    rvalid = 0;
    chk("rsp.late_memres", wb_memres, 0);
    chk("rsp.late_alures", wb_alures, 0);
    dbg = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
